// File: rtl/arb_response_router.sv
// ============================================================================
// arb_response_router : in-order ID FIFO routing target responses to requesters
// Rev 1.0
// ============================================================================
`default_nettype none

module arb_response_router #(
   parameter int REQUASTERS_QUANT = 4,
   parameter int DEPTH            = 4,
   parameter int DATA_W           = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [REQUASTERS_QUANT-1:0]   grants,
   input  logic                          req_accept,
   output logic                          stall,
   input  logic                          rsp_valid,
   input  logic [DATA_W-1:0]             rsp_data,
   output logic                          rsp_ready,
   output logic [REQUASTERS_QUANT-1:0]   out_valid,
   output logic [DATA_W-1:0]             out_data,
   output logic [$clog2(DEPTH+1)-1:0]    outstanding,
   output logic                          err
);

   localparam int IDX_W = $clog2(REQUASTERS_QUANT);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [IDX_W-1:0] fifo_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [IDX_W-1:0] push_idx;
   logic             any_grant;
   logic             grant_onehot;
   logic             push;
   logic             pop;

   assign stall        = (outstanding == CNT_W'(DEPTH));
   assign rsp_ready    = (outstanding != '0);
   assign any_grant    = |grants;
   assign grant_onehot = any_grant && ((grants & (grants - 1'b1)) == '0);
   assign pop          = rsp_valid & rsp_ready;
   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign push         = req_accept & any_grant & (~stall | pop);

   always_comb begin
      push_idx = '0;
      for (int i = REQUASTERS_QUANT - 1; i >= 0; i--) begin
         if (grants[i]) push_idx = IDX_W'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) fifo_mem[wr_ptr] <= push_idx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         outstanding <= '0;
         out_valid   <= '0;
         out_data    <= '0;
         err         <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;

         if (push && !pop)      outstanding <= outstanding + 1'b1;
         else if (pop && !push) outstanding <= outstanding - 1'b1;

         if (pop) begin
            out_valid <= REQUASTERS_QUANT'(1) << fifo_mem[rd_ptr];
            out_data  <= rsp_data;
         end else begin
            out_valid <= '0;
         end

         if ((req_accept && any_grant && stall && !pop) ||
             (rsp_valid && !rsp_ready) ||
             (req_accept && !grant_onehot))
            err <= 1'b1;
      end
   end

endmodule

`default_nettype wire
